// File: rtl/i_fetch_unit.sv
// ---------------------------------------------------------------------------
// i_fetch_unit
//   Instruction fetch stage that sits directly upstream of i_cache_v2.
//   It owns the fetch PC and issues at most one read per cycle to a
//   single-cycle synchronous instruction SRAM. Each returned word is captured
//   together with its PC in a 2-entry skid FIFO and handed to decode over a
//   valid/ready handshake. A redirect flushes both the buffered and the
//   in-flight fetches and restarts fetch at the new (word-aligned) address.
//
// Parameters
//   RESET_PC      PC of the first fetch after reset
//   I_SLICE_SIZE  I-memory size in bytes (must match i_cache_v2 i_slice_size)
//   FIFO_DEPTH    skid FIFO entries (fixed at 2: sized for 1 instr/cycle)
//
// Ports
//   clk             in   core clock
//   rst_n           in   asynchronous active-low reset
//   fetch_en        in   run enable; 0 stops new fetches
//   redirect_valid  in   flush and restart fetch at redirect_pc
//   redirect_pc     in   new fetch address, bits [1:0] ignored
//   ic_enable       out  read strobe to i_cache_v2
//   ic_read         out  constant 1 (fetch never writes)
//   ic_address      out  word-aligned fetch address
//   ic_store        out  constant 0
//   ic_fetch        in   read data, valid the cycle after ic_enable
//   inst_valid      out  head FIFO entry valid toward decode
//   inst_ready      in   decode accepts the head entry
//   inst_data       out  instruction word of the head entry
//   inst_pc         out  PC of the head entry
// ---------------------------------------------------------------------------
module i_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned I_SLICE_SIZE = 8192,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_enable,
  output logic        ic_read,
  output logic [31:0] ic_address,
  output logic [31:0] ic_store,
  input  logic [31:0] ic_fetch,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  // Fetch PC and in-flight request tracking
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight;
  logic        r_kill;

  // Skid FIFO, entry 0 is always the head
  logic [1:0]  r_count;
  logic [31:0] r_fifo_pc   [FIFO_DEPTH];
  logic [31:0] r_fifo_data [FIFO_DEPTH];

  logic [31:0] w_redirect_pc;
  logic [31:0] w_fetch_addr;
  logic [2:0]  w_occupancy;
  logic        w_room;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  // Buffered entries plus the one response that may still be in flight
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_room      = (w_occupancy < 3'(FIFO_DEPTH));

  // A redirect hides the head so no handshake can happen in that cycle
  assign inst_valid = (r_count != 2'd0) & ~redirect_valid;
  assign w_pop      = inst_valid & inst_ready;

  // rst_n gates the strobe so it drops the moment reset is asserted
  assign w_issue = rst_n & fetch_en & (redirect_valid | w_room | w_pop);

  // Responses landing in a redirect cycle, or marked stale, are discarded
  assign w_push = r_inflight & ~r_kill & ~redirect_valid;

  assign w_fetch_addr = redirect_valid ? w_redirect_pc : r_pc;

  assign ic_enable  = w_issue;
  assign ic_address = w_fetch_addr;
  assign ic_read    = 1'b1;
  assign ic_store   = '0;

  assign inst_data = r_fifo_data[0];
  assign inst_pc   = r_fifo_pc[0];

  // -------------------------------------------------------------------------
  // PC / request control
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= w_fetch_addr + 32'd4;
        r_inflight_pc <= w_fetch_addr;
      end else if (redirect_valid) begin
        r_pc <= w_redirect_pc;
      end
      // A request issued in the redirect cycle already belongs to the new
      // stream, so only an older outstanding request is ever marked stale.
      r_kill <= redirect_valid & r_inflight & ~w_issue;
    end
  end

  // -------------------------------------------------------------------------
  // Skid FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          // Push only happens with count < 2, so bit 0 selects the free slot
          r_fifo_pc[r_count[0]]   <= r_inflight_pc;
          r_fifo_data[r_count[0]] <= ic_fetch;
          r_count                 <= r_count + 2'd1;
        end
        2'b01: begin
          r_fifo_pc[0]   <= r_fifo_pc[1];
          r_fifo_data[0] <= r_fifo_data[1];
          r_count        <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_fifo_pc[0]   <= r_inflight_pc;
            r_fifo_data[0] <= ic_fetch;
          end else begin
            r_fifo_pc[0]   <= r_fifo_pc[1];
            r_fifo_data[0] <= r_fifo_data[1];
            r_fifo_pc[1]   <= r_inflight_pc;
            r_fifo_data[1] <= ic_fetch;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Design-error checks
  // -------------------------------------------------------------------------
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count >= 2'(FIFO_DEPTH))));

  a_slice_pow2: assert property (@(posedge clk) disable iff (!rst_n)
    (((I_SLICE_SIZE & (I_SLICE_SIZE - 1)) == 0) && (I_SLICE_SIZE >= 8)));

endmodule

// File: tb/tb_i_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_i_fetch_unit
//   Directed and randomized bench for i_fetch_unit. Instance A starts at PC 0,
//   instance B at 0xFFFF_FFF8 to exercise PC wrap; both share control inputs.
//   A scoreboard tracks the next PC decode must see (sequential PCs, reset to
//   RESET_PC on reset, replaced by the aligned target on redirect) and checks
//   every valid head entry and its memory word against it.
// ---------------------------------------------------------------------------
module tb_i_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;

  logic        ic_enable_a, ic_read_a, inst_valid_a;
  logic [31:0] ic_address_a, ic_store_a, ic_fetch_a, inst_data_a, inst_pc_a;
  logic        ic_enable_b, ic_read_b, inst_valid_b;
  logic [31:0] ic_address_b, ic_store_b, ic_fetch_b, inst_data_b, inst_pc_b;

  logic [31:0] mem [2048];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;
  int unsigned n_deliv  = 0;

  always #5 clk = ~clk;

  i_fetch_unit #(.RESET_PC(32'h0000_0000), .I_SLICE_SIZE(8192), .FIFO_DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_enable(ic_enable_a), .ic_read(ic_read_a), .ic_address(ic_address_a),
    .ic_store(ic_store_a), .ic_fetch(ic_fetch_a),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready),
    .inst_data(inst_data_a), .inst_pc(inst_pc_a)
  );

  i_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .I_SLICE_SIZE(8192), .FIFO_DEPTH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_enable(ic_enable_b), .ic_read(ic_read_b), .ic_address(ic_address_b),
    .ic_store(ic_store_b), .ic_fetch(ic_fetch_b),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready),
    .inst_data(inst_data_b), .inst_pc(inst_pc_b)
  );

  // Single-cycle synchronous SRAM indexed by address[12:2]
  always @(posedge clk) begin
    if (ic_enable_a) ic_fetch_a <= mem[ic_address_a[12:2]];
    if (ic_enable_b) ic_fetch_b <= mem[ic_address_b[12:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return mem[pc[12:2]];
  endfunction

  // Reference model for instance A: next PC that decode should receive
  logic [31:0] exp_pc = 32'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 32'h0;
    end else if (redirect_valid) begin
      chk("sb_redirect_valid_low", {31'b0, inst_valid_a}, 32'd0);
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (inst_valid_a) begin
      chk("sb_head_pc", inst_pc_a, exp_pc);
      chk("sb_head_data", inst_data_a, mem_word(exp_pc));
      if (inst_ready) begin
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e;
    int unsigned deliv_start;

    rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000 + 32'(i);

    // ---------------- reset state ----------------
    repeat (3) nc();
    smp();
    chk("rst_ic_enable", {31'b0, ic_enable_a}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid_a}, 32'd0);
    chk("rst_ic_address", ic_address_a, 32'h0);
    chk("rst_ic_address_b", ic_address_b, 32'hFFFF_FFF8);
    chk("ic_read_const", {31'b0, ic_read_a}, 32'd1);
    chk("ic_store_const", ic_store_a, 32'h0);

    // ---------------- streaming + PC wrap on B ----------------
    nc(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("seq_ic_enable", {31'b0, ic_enable_a}, 32'd1);
      chk("seq_ic_address", ic_address_a, 32'(4 * k));
      if (k < 2) begin
        chk("seq_latency_valid", {31'b0, inst_valid_a}, 32'd0);
      end else begin
        chk("seq_valid", {31'b0, inst_valid_a}, 32'd1);
        chk("seq_pc", inst_pc_a, 32'(4 * (k - 2)));
        chk("seq_data", inst_data_a, 32'h1000 + 32'(k - 2));
        e = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        chk("wrap_pc", inst_pc_b, e);
        chk("wrap_data", inst_data_b, 32'h1000 + {21'b0, e[12:2]});
      end
      nc();
    end

    // ---------------- backpressure ----------------
    rst_n = 1'b0; inst_ready = 1'b0;
    nc(); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      inst_ready = (k >= 7);
      smp();
      if (k < 2 || k >= 7) chk("bp_ic_enable_on", {31'b0, ic_enable_a}, 32'd1);
      else                 chk("bp_ic_enable_off", {31'b0, ic_enable_a}, 32'd0);
      if (k >= 2) chk("bp_valid", {31'b0, inst_valid_a}, 32'd1);
      if (k >= 2 && k <= 7) chk("bp_hold_pc", inst_pc_a, 32'h0);
      if (k == 8) chk("bp_pc4", inst_pc_a, 32'h4);
      if (k == 9) chk("bp_pc8", inst_pc_a, 32'h8);
      nc();
    end
    repeat (2) nc();

    // ---------------- redirect ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    smp();
    chk("redir_valid_low", {31'b0, inst_valid_a}, 32'd0);
    chk("redir_ic_address", ic_address_a, 32'h100);
    chk("redir_ic_enable", {31'b0, ic_enable_a}, 32'd1);
    nc(); redirect_valid = 1'b0;
    smp(); chk("redir_bubble", {31'b0, inst_valid_a}, 32'd0);
    nc();
    smp(); chk("redir_first_pc", inst_pc_a, 32'h100);
    chk("redir_first_valid", {31'b0, inst_valid_a}, 32'd1);
    nc();
    smp(); chk("redir_second_pc", inst_pc_a, 32'h104);
    nc();

    // ---------------- back-to-back redirects ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    nc(); redirect_pc = 32'h80;
    smp(); chk("b2b_ic_address", ic_address_a, 32'h80);
    nc(); redirect_valid = 1'b0;
    smp(); chk("b2b_bubble", {31'b0, inst_valid_a}, 32'd0);
    nc();
    smp(); chk("b2b_first_pc", inst_pc_a, 32'h80);
    nc();
    smp(); chk("b2b_second_pc", inst_pc_a, 32'h84);
    nc();
    nc();

    // ---------------- fetch_en drop ----------------
    fetch_en = 1'b0;
    smp();
    chk("fe_ic_enable_off", {31'b0, ic_enable_a}, 32'd0);
    chk("fe_head_pc", inst_pc_a, 32'h8C);
    nc();
    smp();
    chk("fe_inflight_valid", {31'b0, inst_valid_a}, 32'd1);
    chk("fe_inflight_pc", inst_pc_a, 32'h90);
    nc();
    for (int k = 0; k < 2; k++) begin
      smp();
      chk("fe_drained", {31'b0, inst_valid_a}, 32'd0);
      chk("fe_no_issue", {31'b0, ic_enable_a}, 32'd0);
      nc();
    end
    fetch_en = 1'b1;
    smp(); chk("fe_resume_addr", ic_address_a, 32'h94);
    nc(); nc();
    smp(); chk("fe_resume_pc", inst_pc_a, 32'h94);
    nc(); nc();

    // ---------------- reset mid-stream ----------------
    rst_n = 1'b0;
    #1;
    chk("mrst_ic_enable", {31'b0, ic_enable_a}, 32'd0);
    chk("mrst_inst_valid", {31'b0, inst_valid_a}, 32'd0);
    smp(); chk("mrst_ic_address", ic_address_a, 32'h0);
    nc(); rst_n = 1'b1;
    smp();
    chk("mrst_restart_en", {31'b0, ic_enable_a}, 32'd1);
    chk("mrst_restart_addr", ic_address_a, 32'h0);
    nc(); nc();
    smp(); chk("mrst_first_pc", inst_pc_a, 32'h0);
    nc();

    // ---------------- randomized traffic ----------------
    rst_n = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    nc(); rst_n = 1'b1;
    deliv_start = n_deliv;
    for (int c = 0; c < 2000; c++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 9) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = $urandom;
      nc();
    end
    redirect_valid = 1'b0;
    chk("rand_throughput", {31'b0, (n_deliv - deliv_start) > 500}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
